// File: rtl/control_sequencer.sv
// SAP-1 control sequencer: a T-state ring plus microcode decode that turns the IR
// opcode and latched flags into every bus enable/load strobe on the 8-bit bus.
module control_sequencer #(
    parameter int OPW     = 4,
    parameter int TSTATES = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           carry_flag,
    input  logic           zero_flag,
    output logic           pc_en,
    output logic           pc_out,
    output logic           pc_load,
    output logic           mar_in,
    output logic           ram_out,
    output logic           ram_in,
    output logic           ir_in,
    output logic           ir_out,
    output logic           a_in,
    output logic           a_lower_in,
    output logic           a_out,
    output logic           b_in,
    output logic           alu_out,
    output logic           sub,
    output logic           flags_in,
    output logic           out_in,
    output logic           halted,
    output logic [2:0]     tstate
);

    typedef struct packed {
        logic pc_en;
        logic pc_out;
        logic pc_load;
        logic mar_in;
        logic ram_out;
        logic ram_in;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_lower_in;
        logic a_out;
        logic b_in;
        logic alu_out;
        logic sub;
        logic flags_in;
        logic out_in;
    } ctrl_t;

    localparam logic [OPW-1:0] OP_LDA = OPW'(4'h1);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4'h2);
    localparam logic [OPW-1:0] OP_SUB = OPW'(4'h3);
    localparam logic [OPW-1:0] OP_STA = OPW'(4'h4);
    localparam logic [OPW-1:0] OP_LDI = OPW'(4'h5);
    localparam logic [OPW-1:0] OP_JMP = OPW'(4'h6);
    localparam logic [OPW-1:0] OP_JC  = OPW'(4'h7);
    localparam logic [OPW-1:0] OP_JZ  = OPW'(4'h8);
    localparam logic [OPW-1:0] OP_OUT = OPW'(4'he);
    localparam logic [OPW-1:0] OP_HLT = OPW'(4'hf);

    localparam logic [2:0] T_LAST = 3'(TSTATES - 1);

    logic [2:0] tstate_q, tstate_d;
    logic       halted_q, halted_d;
    ctrl_t      cw;

    // HLT freezes the ring on the edge that ends T2; only reset releases it.
    always_comb begin
        tstate_d = tstate_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (tstate_q == 3'd2 && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else if (tstate_q == T_LAST) begin
                tstate_d = '0;
            end else begin
                tstate_d = tstate_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tstate_q <= '0;
            halted_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
            tstate_q <= tstate_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        // NOTE: the whole word defaults to zero first, so no strobe can infer a latch.
        cw = '0;
        if (rst && !halted_q) begin
            case (tstate_q)
                3'd0: begin
                    cw.pc_out = 1'b1;
                    cw.mar_in = 1'b1;
                end
                3'd1: begin
                    cw.ram_out = 1'b1;
                    cw.ir_in   = 1'b1;
                    cw.pc_en   = 1'b1;
                end
                3'd2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            cw.ir_out = 1'b1;
                            cw.mar_in = 1'b1;
                        end
                        OP_LDI: begin
                            cw.ir_out     = 1'b1;
                            cw.a_lower_in = 1'b1;
                        end
                        OP_JMP: begin
                            cw.ir_out  = 1'b1;
                            cw.pc_load = 1'b1;
                        end
                        OP_JC: begin
                            cw.ir_out  = 1'b1;
                            cw.pc_load = carry_flag;
                        end
                        OP_JZ: begin
                            cw.ir_out  = 1'b1;
                            cw.pc_load = zero_flag;
                        end
                        OP_OUT: begin
                            cw.a_out  = 1'b1;
                            cw.out_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd3: begin
                    case (opcode)
                        OP_LDA: begin
                            cw.ram_out = 1'b1;
                            cw.a_in    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            cw.ram_out = 1'b1;
                            cw.b_in    = 1'b1;
                        end
                        OP_STA: begin
                            cw.a_out  = 1'b1;
                            cw.ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        cw.alu_out  = 1'b1;
                        cw.a_in     = 1'b1;
                        cw.flags_in = 1'b1;
                        cw.sub      = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pc_en      = cw.pc_en;
    assign pc_out     = cw.pc_out;
    assign pc_load    = cw.pc_load;
    assign mar_in     = cw.mar_in;
    assign ram_out    = cw.ram_out;
    assign ram_in     = cw.ram_in;
    assign ir_in      = cw.ir_in;
    assign ir_out     = cw.ir_out;
    assign a_in       = cw.a_in;
    assign a_lower_in = cw.a_lower_in;
    assign a_out      = cw.a_out;
    assign b_in       = cw.b_in;
    assign alu_out    = cw.alu_out;
    assign sub        = cw.sub;
    assign flags_in   = cw.flags_in;
    assign out_in     = cw.out_in;
    assign halted     = halted_q;
    assign tstate     = tstate_q;

endmodule
